// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment patterns (g..a, active-high) and the decode result type.
// The same constants are used by the encoder so both directions stay in lockstep.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h58;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef struct packed {
        logic       legal;
        logic [3:0] value;
    } seg_dec_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational 7-segment pattern to hex decoder; illegal patterns flag legal=0 and read as F.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern_i,
    output seg_dec_t   dec_o
);

    always_comb begin
        dec_o.legal = 1'b1;
        dec_o.value = 4'hF;
        case (pattern_i)
            SEG_0:     dec_o.value = 4'h0;
            SEG_1:     dec_o.value = 4'h1;
            SEG_2:     dec_o.value = 4'h2;
            SEG_3:     dec_o.value = 4'h3;
            SEG_4:     dec_o.value = 4'h4;
            SEG_5:     dec_o.value = 4'h5;
            SEG_6:     dec_o.value = 4'h6;
            SEG_7:     dec_o.value = 4'h7;
            SEG_8:     dec_o.value = 4'h8;
            SEG_9:     dec_o.value = 4'h9;
            SEG_A:     dec_o.value = 4'hA;
            SEG_B:     dec_o.value = 4'hB;
            SEG_C:     dec_o.value = 4'hC;
            SEG_D:     dec_o.value = 4'hD;
            SEG_E:     dec_o.value = 4'hE;
            // Blank deliberately aliases hex F, matching the encoder.
            SEG_BLANK: dec_o.value = 4'hF;
            default:   dec_o.legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_capture_decoder.sv
// Passive monitor of a multiplexed 7-segment bus: synchronises, waits for a stable sample,
// then decodes the pattern into the enabled digit's register.
module seg7_capture_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 4,
    localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              segments_i,
    input  logic [NUM_DIGITS-1:0]   digit_sel_i,
    output logic [4*NUM_DIGITS-1:0] digit_values_o,
    output logic [NUM_DIGITS-1:0]   digit_valid_o,
    output logic [NUM_DIGITS-1:0]   digit_dp_o,
    output logic                    update_o,
    output logic [IdxW-1:0]         update_idx_o,
    output logic                    pattern_err_o,
    output logic                    sel_err_o,
    output logic [7:0]              err_count_o
);

    localparam int unsigned SW   = NUM_DIGITS + 8;
    localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);

    logic [SW-1:0]   sync_q [SYNC_STAGES];
    logic [SW-1:0]   s, s_prev_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            capture;

    logic [NUM_DIGITS-1:0] sel;
    logic                  sel_zero, sel_onehot;
    logic [IdxW-1:0]       sel_idx;
    seg_dec_t              dec;

    logic [4*NUM_DIGITS-1:0] values_q, values_d;
    logic [NUM_DIGITS-1:0]   valid_q, valid_d, dp_q, dp_d;
    logic                    update_q, update_d, perr_q, perr_d, serr_q, serr_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [7:0]              err_q, err_d;
    logic                    err_inc;

    assign s       = sync_q[SYNC_STAGES-1];
    assign sel     = s[SW-1:8];
    assign capture = (s == s_prev_q) && (cnt_q == CntW'(STABLE_CYCLES - 1));

    assign sel_zero   = (sel == '0);
    assign sel_onehot = !sel_zero && ((sel & (sel - NUM_DIGITS'(1))) == '0);

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel[i]) sel_idx = IdxW'(i);
        end
    end

    seg7_pattern_decode u_decode (
        .pattern_i (s[6:0]),
        .dec_o     (dec)
    );

    // Counter saturates so a held pattern captures exactly once.
    always_comb begin
        cnt_d = cnt_q;
        if (s != s_prev_q) begin
            cnt_d = '0;
        end else if (cnt_q != CntW'(STABLE_CYCLES)) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_comb begin
        values_d = values_q;
        valid_d  = valid_q;
        dp_d     = dp_q;
        idx_d    = idx_q;
        update_d = 1'b0;
        perr_d   = 1'b0;
        serr_d   = 1'b0;
        err_inc  = 1'b0;
        if (capture) begin
            if (sel_onehot) begin
                values_d[4*sel_idx +: 4] = dec.value;
                valid_d[sel_idx]         = dec.legal;
                dp_d[sel_idx]            = s[7];
                idx_d                    = sel_idx;
                update_d                 = 1'b1;
                perr_d                   = !dec.legal;
                err_inc                  = !dec.legal;
            end else if (!sel_zero) begin
                serr_d  = 1'b1;
                err_inc = 1'b1;
            end
        end
        err_d = (err_inc && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            s_prev_q <= '0;
            cnt_q    <= '0;
            values_q <= '0;
            valid_q  <= '0;
            dp_q     <= '0;
            idx_q    <= '0;
            update_q <= 1'b0;
            perr_q   <= 1'b0;
            serr_q   <= 1'b0;
            err_q    <= '0;
        end else begin
            sync_q[0] <= {digit_sel_i, segments_i};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            s_prev_q <= s;
            cnt_q    <= cnt_d;
            values_q <= values_d;
            valid_q  <= valid_d;
            dp_q     <= dp_d;
            idx_q    <= idx_d;
            update_q <= update_d;
            perr_q   <= perr_d;
            serr_q   <= serr_d;
            err_q    <= err_d;
        end
    end

    assign digit_values_o = values_q;
    assign digit_valid_o  = valid_q;
    assign digit_dp_o     = dp_q;
    assign update_o       = update_q;
    assign update_idx_o   = idx_q;
    assign pattern_err_o  = perr_q;
    assign sel_err_o      = serr_q;
    assign err_count_o    = err_q;

endmodule
